// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the round-robin bus arbiter: state encoding,
// index-width helper and the default watchdog limit.
package bus_arbiter_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANT   = 2'd1;
    localparam logic [1:0] ST_BUSY    = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        GRANT   = ST_GRANT,
        BUSY    = ST_BUSY,
        RELEASE = ST_RELEASE
    } arb_state_t;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

    // Bits needed to index n masters (at least one).
    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin winner search: first set request at or above
// the pointer, wrapping modulo NUM_MASTERS.
module rr_priority_picker
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 4
) (
    input  logic [NUM_MASTERS-1:0]            request,
    input  logic [idx_width(NUM_MASTERS)-1:0] pointer,
    output logic [NUM_MASTERS-1:0]            winner_onehot,
    output logic [idx_width(NUM_MASTERS)-1:0] winner_index,
    output logic                              winner_valid
);

    localparam int unsigned IW = idx_width(NUM_MASTERS);

    logic [IW-1:0] slot [NUM_MASTERS];

    // slot[i] is the master examined i places after the pointer
    always_comb begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
            slot[i] = IW'((32'(pointer) + 32'(i)) % NUM_MASTERS);
        end
    end

    always_comb begin
        winner_index = '0;
        winner_valid = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!winner_valid && request[slot[i]]) begin
                winner_index = slot[i];
                winner_valid = 1'b1;
            end
        end
        winner_onehot = winner_valid ? (NUM_MASTERS'(1) << winner_index) : '0;
    end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin bus arbiter with sticky grants and one idle cycle between owners.
// Define ARBITER_TIMEOUT_EN to build the watchdog that drives errorOUT.
module bus_arbiter_rr
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned NUM_MASTERS    = 4,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [NUM_MASTERS-1:0]            request,
    output logic [NUM_MASTERS-1:0]            granted,
    input  logic                              begin_transactionIN,
    input  logic                              end_transactionIN,
    input  logic                              errorIN,
    output logic                              errorOUT,
    output logic                              busIdle,
    output logic [idx_width(NUM_MASTERS)-1:0] grantIndex
);

    localparam int unsigned IW = idx_width(NUM_MASTERS);

    if (NUM_MASTERS < 2 || NUM_MASTERS > 8) begin : g_bad_num_masters
        $error("bus_arbiter_rr: NUM_MASTERS must be 2..8");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("bus_arbiter_rr: TIMEOUT_CYCLES must be 1..65535");
    end

    arb_state_t             state;
    arb_state_t             state_next;
    logic [IW-1:0]          pointer;
    logic [IW-1:0]          pointer_next;
    logic [NUM_MASTERS-1:0] granted_next;
    logic [IW-1:0]          grant_index_next;
    logic [NUM_MASTERS-1:0] pick_onehot;
    logic [IW-1:0]          pick_index;
    logic                   pick_valid;
    logic                   abort;

    rr_priority_picker #(
        .NUM_MASTERS (NUM_MASTERS)
    ) u_picker (
        .request       (request),
        .pointer       (pointer),
        .winner_onehot (pick_onehot),
        .winner_index  (pick_index),
        .winner_valid  (pick_valid)
    );

    // A watchdog pulse on errorOUT aborts the owner exactly like a bus error.
    assign abort = errorIN | errorOUT;

    always_comb begin
        state_next       = state;
        pointer_next     = pointer;
        granted_next     = granted;
        grant_index_next = grantIndex;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_next       = GRANT;
                    granted_next     = pick_onehot;
                    grant_index_next = pick_index;
                    pointer_next     = (pick_index == IW'(NUM_MASTERS - 1)) ? '0 : pick_index + 1'b1;
                end
            end
            GRANT: begin
                if (end_transactionIN || abort) begin
                    state_next   = RELEASE;
                    granted_next = '0;
                end else if (begin_transactionIN) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (end_transactionIN || abort) begin
                    state_next   = RELEASE;
                    granted_next = '0;
                end
            end
            RELEASE: begin
                state_next   = IDLE;
                granted_next = '0;
            end
            default: begin
                state_next   = IDLE;
                granted_next = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            pointer    <= '0;
            granted    <= '0;
            grantIndex <= '0;
            busIdle    <= 1'b1;
        end else begin
            state      <= state_next;
            pointer    <= pointer_next;
            granted    <= granted_next;
            grantIndex <= grant_index_next;
            busIdle    <= (state_next == IDLE);
        end
    end

`ifdef ARBITER_TIMEOUT_EN
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] wd_count;
    logic        wd_active;
    logic        wd_fire;

    assign wd_active = (state == GRANT) || (state == BUSY);
    // An end or bus error in the limit cycle wins over the watchdog.
    assign wd_fire   = wd_active && (wd_count == WD_LAST) && !end_transactionIN && !errorIN;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wd_count <= '0;
            errorOUT <= 1'b0;
        end else begin
            errorOUT <= wd_fire;
            wd_count <= wd_active ? 16'(wd_count + 16'd1) : '0;
        end
    end
`else
    assign errorOUT = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Self-checking bench for bus_arbiter_rr: directed scenarios plus random
// traffic compared against an owner/pointer reference model.
module tb_bus_arbiter_rr;

    localparam int N = 4;
    localparam int T = 10;
`ifdef ARBITER_TIMEOUT_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] request = '0;
    logic [N-1:0] granted;
    logic         begin_tr = 1'b0;
    logic         end_tr = 1'b0;
    logic         error_in = 1'b0;
    logic         errorOUT;
    logic         busIdle;
    logic [1:0]   grantIndex;

    bus_arbiter_rr #(
        .NUM_MASTERS    (N),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .request             (request),
        .granted             (granted),
        .begin_transactionIN (begin_tr),
        .end_transactionIN   (end_tr),
        .errorIN             (error_in),
        .errorOUT            (errorOUT),
        .busIdle             (busIdle),
        .grantIndex          (grantIndex)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: who owns the bus, idle gap pending, fairness pointer.
    int m_owner;
    int m_last;
    int m_ptr;
    int m_age;
    bit m_gap;
    bit m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_last  = 0;
        m_ptr   = 0;
        m_age   = 0;
        m_gap   = 1'b0;
        m_err   = 1'b0;
    endtask

    task automatic model_step(input logic [N-1:0] req, input logic b, input logic e, input logic er);
        bit pulse;
        bit found;
        pulse = 1'b0;
        found = 1'b0;
        if (m_owner >= 0) begin
            if (e || er || m_err) begin
                m_owner = -1;
                m_gap   = 1'b1;
            end else begin
                if (WD_EN && m_age == T - 1) pulse = 1'b1;
                m_age++;
            end
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (!found && req[j[1:0]]) begin
                    found   = 1'b1;
                    m_owner = j;
                    m_last  = j;
                    m_ptr   = (j + 1) % N;
                    m_age   = 0;
                end
            end
        end
        m_err = pulse;
        if (b) begin end
    endtask

    task automatic check_outputs();
        logic [N-1:0] eg;
        eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        check("granted", 32'(granted), 32'(eg));
        check("busIdle", 32'(busIdle), 32'((m_owner < 0) && !m_gap));
        check("grantIndex", 32'(grantIndex), 32'(m_last));
        check("errorOUT", 32'(errorOUT), 32'(m_err));
    endtask

    task automatic cycle(input logic [N-1:0] req, input logic b, input logic e, input logic er);
        request  = req;
        begin_tr = b;
        end_tr   = e;
        error_in = er;
        @(posedge clock);
        model_step(req, b, e, er);
        #1;
        check_outputs();
    endtask

    task automatic apply_reset();
        request  = '0;
        begin_tr = 1'b0;
        end_tr   = 1'b0;
        error_in = 1'b0;
        reset    = 1'b0;
        model_reset();
        #1;
        check("rst_granted", 32'(granted), 32'd0);
        check("rst_busIdle", 32'(busIdle), 32'd1);
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic wait_grant(input logic [N-1:0] req);
        int w;
        w = 0;
        cycle(req, 1'b0, 1'b0, 1'b0);
        while (granted == '0 && w < 5) begin
            cycle(req, 1'b0, 1'b0, 1'b0);
            w++;
        end
        check("grant_arrived", 32'(granted != '0), 32'd1);
    endtask

    int exp_order [5] = '{0, 1, 2, 3, 0};

    initial begin
        model_reset();
        #1 reset = 1'b0;
        #1;
        check("rst_granted", 32'(granted), 32'd0);
        check("rst_errorOUT", 32'(errorOUT), 32'd0);
        check("rst_busIdle", 32'(busIdle), 32'd1);
        check("rst_grantIndex", 32'(grantIndex), 32'd0);
        @(negedge clock);
        reset = 1'b1;

        // single requester, DMA-style single word
        cycle(4'b0010, 1'b0, 1'b0, 1'b0);
        check("single_grant", 32'(granted), 32'h2);
        cycle(4'b0000, 1'b0, 1'b0, 1'b0);
        cycle(4'b0000, 1'b1, 1'b0, 1'b0);
        cycle(4'b0000, 1'b0, 1'b1, 1'b0);
        check("single_release", 32'(granted), 32'h0);
        check("single_index", 32'(grantIndex), 32'd1);
        cycle(4'b0000, 1'b0, 1'b0, 1'b0);

        // round-robin fairness with all masters requesting
        apply_reset();
        for (int g = 0; g < 5; g++) begin
            wait_grant(4'b1111);
            check("rr_order", 32'(grantIndex), 32'(exp_order[g]));
            cycle(4'b1111, 1'b1, 1'b0, 1'b0);
            cycle(4'b1111, 1'b0, 1'b0, 1'b0);
            cycle(4'b1111, 1'b0, 1'b1, 1'b0);
            check("rr_gap", 32'(granted), 32'h0);
        end

        // sticky grant after the request is dropped
        apply_reset();
        cycle(4'b0100, 1'b0, 1'b0, 1'b0);
        check("sticky_grant", 32'(granted), 32'h4);
        for (int k = 0; k < 4; k++) begin
            cycle(4'b0000, k == 1, 1'b0, 1'b0);
            check("sticky_hold", 32'(granted), 32'h4);
        end
        cycle(4'b0000, 1'b0, 1'b1, 1'b0);
        check("sticky_release", 32'(granted), 32'h0);

        // bus error in BUSY aborts; pointer already moved past master 2
        apply_reset();
        cycle(4'b0100, 1'b0, 1'b0, 1'b0);
        cycle(4'b0000, 1'b1, 1'b0, 1'b0);
        cycle(4'b0000, 1'b0, 1'b0, 1'b0);
        cycle(4'b0000, 1'b0, 1'b0, 1'b1);
        check("err_release", 32'(granted), 32'h0);
        wait_grant(4'b1011);
        check("err_next_owner", 32'(grantIndex), 32'd3);
        cycle(4'b0000, 1'b0, 1'b1, 1'b0);
        cycle(4'b0000, 1'b0, 1'b0, 1'b0);

`ifdef ARBITER_TIMEOUT_EN
        // watchdog fires when the owner never ends
        apply_reset();
        cycle(4'b0001, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k < T; k++) cycle(4'b0000, 1'b0, 1'b0, 1'b0);
        cycle(4'b0000, 1'b0, 1'b0, 1'b0);
        check("wd_pulse", 32'(errorOUT), 32'd1);
        check("wd_still_granted", 32'(granted), 32'h1);
        cycle(4'b0000, 1'b0, 1'b0, 1'b0);
        check("wd_release", 32'(granted), 32'h0);
        check("wd_pulse_end", 32'(errorOUT), 32'd0);
        cycle(4'b0000, 1'b0, 1'b0, 1'b0);
`endif

        // asynchronous reset while BUSY
        apply_reset();
        cycle(4'b0001, 1'b0, 1'b0, 1'b0);
        cycle(4'b0000, 1'b1, 1'b0, 1'b0);
        #3 reset = 1'b0;
        model_reset();
        #1;
        check("async_granted", 32'(granted), 32'h0);
        check("async_busIdle", 32'(busIdle), 32'd1);
        #2 reset = 1'b1;
        cycle(4'b1000, 1'b0, 1'b0, 1'b0);
        check("post_reset_grant", 32'(granted), 32'h8);
        cycle(4'b0000, 1'b0, 1'b1, 1'b0);
        cycle(4'b0000, 1'b0, 1'b0, 1'b0);

        // random traffic against the model
        apply_reset();
        for (int k = 0; k < 800; k++) begin
            cycle(N'($urandom_range(0, 15)),
                  $urandom_range(0, 9) < 3,
                  $urandom_range(0, 9) < 2,
                  $urandom_range(0, 24) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
